// File: rtl/pk_gen_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pk_gen_scheduler_if                                                        |
// | Request/response bundle between the cipher front-ends and pk_gen_scheduler.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface pk_gen_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] sec_key;
  logic [NUM_REQ-1:0]   ack;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [7:0]           rsp_pub_key;
  logic                 rsp_err;
  logic                 busy;

  modport master (
    output req, sec_key, rsp_ready,
    input  ack, rsp_valid, rsp_id, rsp_pub_key, rsp_err, busy
  );

  modport slave (
    input  req, sec_key, rsp_ready,
    output ack, rsp_valid, rsp_id, rsp_pub_key, rsp_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/pk_gen_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pk_gen_scheduler                                                           |
// | Round-robin sharing of one Pk = (Sk + Q) mod P datapath between NUM_REQ    |
// | requesters. Optional macro PKG_ERR_COUNT_EN adds a saturating error count. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pk_gen_scheduler #(
  parameter int         NUM_REQ = 4,
  parameter int         ID_W    = $clog2(NUM_REQ),
  parameter logic [7:0] P_MOD   = 8'd227,
  parameter logic [7:0] Q_OFF   = 8'd225
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef PKG_ERR_COUNT_EN
  input  logic       err_count_clr,
  output logic [7:0] err_count,
`endif
  pk_gen_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [7:0]         key_q, key_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic [7:0]         rsp_pk_q, rsp_pk_d;
  logic               rsp_err_q, rsp_err_d;

  logic               grant_found;
  logic [ID_W-1:0]    grant_id;
  logic [ID_W-1:0]    cand;
  int                 idx;
  logic               calc_err;
  logic [8:0]         calc_sum;
  logic [8:0]         calc_red;
  logic [7:0]         calc_pk;
  logic               rsp_hs;
  logic [7:0]         keys [NUM_REQ];

  generate
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_key_unpack
      assign keys[g] = bus.sec_key[8*g +: 8];
    end
  endgenerate

  assign rsp_hs = (state_q == ST_RESP) && bus.rsp_ready;

  // Scan requesters starting at the pointer so the last winner goes to the back.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    idx         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = ID_W'(idx);
      if (!grant_found && bus.req[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  // Sum of 227 is kept as-is, so valid keys map onto 1..227 rather than 0..226.
  always_comb begin
    calc_err = (key_q == 8'd0) || (key_q >= P_MOD);
    calc_sum = {1'b0, key_q} + {1'b0, Q_OFF};
    calc_red = calc_sum - {1'b0, P_MOD};
    if (calc_sum <= {1'b0, P_MOD}) calc_pk = calc_sum[7:0];
    else                           calc_pk = calc_red[7:0];
    if (calc_err) calc_pk = 8'h00;
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    key_d     = key_q;
    ack_d     = '0;
    rsp_id_d  = rsp_id_q;
    rsp_pk_d  = rsp_pk_q;
    rsp_err_d = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          id_d            = grant_id;
          key_d           = keys[grant_id];
          ack_d[grant_id] = 1'b1;
          state_d         = ST_CALC;
        end
      end
      ST_CALC: begin
        rsp_id_d  = id_q;
        rsp_pk_d  = calc_pk;
        rsp_err_d = calc_err;
        state_d   = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_hs) begin
          ptr_d   = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      id_q      <= '0;
      key_q     <= '0;
      ack_q     <= '0;
      rsp_id_q  <= '0;
      rsp_pk_q  <= 8'h00;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      key_q     <= key_d;
      ack_q     <= ack_d;
      rsp_id_q  <= rsp_id_d;
      rsp_pk_q  <= rsp_pk_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign bus.ack         = ack_q;
  assign bus.rsp_valid   = (state_q == ST_RESP);
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_pub_key = rsp_pk_q;
  assign bus.rsp_err     = rsp_err_q;

`ifdef PKG_ERR_COUNT_EN
  logic [7:0] err_count_q, err_count_d;

  // Clear takes priority over an increment in the same cycle.
  always_comb begin
    err_count_d = err_count_q;
    if (err_count_clr) begin
      err_count_d = 8'd0;
    end else if (rsp_hs && rsp_err_q && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) err_count_q <= 8'd0;
    else       err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pk_gen_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pk_gen_scheduler                                                        |
// | Scoreboard bench: the driver predicts grants/results, a monitor checks.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pk_gen_scheduler;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [7:0]      pk;
    logic            err;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  pk_gen_scheduler_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  logic [NUM_REQ-1:0] req_drv     = '0;
  logic [7:0]         key_arr [NUM_REQ];
  logic               ready_fixed = 1'b1;
  logic               rdy_rand    = 1'b0;
  logic               rnd_bit     = 1'b1;

  assign bus.req       = req_drv;
  assign bus.sec_key   = {key_arr[3], key_arr[2], key_arr[1], key_arr[0]};
  assign bus.rsp_ready = rdy_rand ? rnd_bit : ready_fixed;

`ifdef PKG_ERR_COUNT_EN
  logic       err_count_clr = 1'b0;
  logic [7:0] err_count;
`endif

  pk_gen_scheduler #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .P_MOD(8'd227), .Q_OFF(8'd225)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef PKG_ERR_COUNT_EN
    .err_count_clr(err_count_clr),
    .err_count    (err_count),
`endif
    .bus          (bus)
  );

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  exp_t exp_q[$];
  logic [NUM_REQ-1:0] pend = '0;
  int   model_ptr = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: valid keys are 1..226, result is (key+225) mod 227 with 0 shown as 227.
  function automatic exp_t model(input int id, input int key);
    exp_t e;
    int   r;
    e.id = ID_W'(id);
    if (key < 1 || key > 226) begin
      e.err = 1'b1;
      e.pk  = 8'h00;
    end else begin
      r = (key + 225) % 227;
      if (r == 0) r = 227;
      e.err = 1'b0;
      e.pk  = 8'(r);
    end
    return e;
  endfunction

  function automatic int predict(input logic [NUM_REQ-1:0] mask, input int ptr);
    logic [ID_W-1:0] ix;
    for (int k = 0; k < NUM_REQ; k++) begin
      ix = ID_W'((ptr + k) % NUM_REQ);
      if (mask[ix]) return (ptr + k) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic logic [7:0] rand_key();
    logic [7:0] edge_keys [7];
    edge_keys = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd226, 8'd227, 8'd255};
    if ($urandom_range(0, 3) == 0) return edge_keys[$urandom_range(0, 6)];
    return 8'($urandom_range(0, 255));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    rnd_bit = ($urandom_range(0, 9) < 7);
  end

  // Drive pend onto req, push the predicted result, then wait for the grant.
  task automatic grant_one(input bit hold, output int w, output int acyc);
    int              n;
    logic [ID_W-1:0] ix;
    req_drv = pend;
    w  = predict(pend, model_ptr);
    ix = ID_W'(w);
    exp_q.push_back(model(w, int'(key_arr[ix])));
    model_ptr = (w + 1) % NUM_REQ;
    n = 0;
    do begin
      step();
      n++;
    end while (bus.ack == '0 && n < 200);
    check("ack", int'(bus.ack), 1 << w);
    acyc = cyc;
    if (!hold) begin
      pend[ix] = 1'b0;
      req_drv  = pend;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bus.busy || exp_q.size() != 0) && n < 500) begin
      step();
      n++;
    end
    check("drain_busy", int'(bus.busy), 0);
    check("drain_queue", exp_q.size(), 0);
  endtask

  // Monitor: compares presented responses against the head of the scoreboard.
  initial begin
    exp_t e;
    logic prev_ack = 1'b0;
`ifdef PKG_ERR_COUNT_EN
    int   err_model = 0;
`endif
    forever begin
      @(negedge clk);
      if (rst_n) begin
        prev_ack = 1'b0;
`ifdef PKG_ERR_COUNT_EN
        err_model = 0;
`endif
      end else begin
`ifdef PKG_ERR_COUNT_EN
        check("err_count", int'(err_count), err_model);
`endif
        if (prev_ack) check("rsp_latency", int'(bus.rsp_valid), 1);
        if (bus.rsp_valid) begin
          check("ack_during_resp", int'(bus.ack), 0);
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL rsp_unexpected: rsp_valid=1 id=%0d with no expected response", bus.rsp_id);
          end else begin
            e = exp_q[0];
            check("rsp_id", int'(bus.rsp_id), int'(e.id));
            check("rsp_pub_key", int'(bus.rsp_pub_key), int'(e.pk));
            check("rsp_err", int'(bus.rsp_err), int'(e.err));
            if (bus.rsp_ready) begin
              void'(exp_q.pop_front());
`ifdef PKG_ERR_COUNT_EN
              if (e.err && err_model < 255) err_model++;
`endif
            end
          end
        end
`ifdef PKG_ERR_COUNT_EN
        if (err_count_clr) err_model = 0;
`endif
        prev_ack = (bus.ack != '0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int   w, a, last;
    logic [7:0] bkeys [3];
    logic [7:0] ikeys [3];
    for (int i = 0; i < NUM_REQ; i++) key_arr[i] = 8'd0;

    repeat (3) step();
    rst_n = 1'b0;
    check("rst_ack", int'(bus.ack), 0);
    check("rst_rsp_valid", int'(bus.rsp_valid), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_rsp_id", int'(bus.rsp_id), 0);
    check("rst_pub_key", int'(bus.rsp_pub_key), 0);
    check("rst_rsp_err", int'(bus.rsp_err), 0);

    // Single requester 0 with key 1.
    key_arr[0] = 8'd1;
    pend = 4'b0001;
    grant_one(1'b0, w, a);
    step();
    check("first_rsp_pub_key", int'(bus.rsp_pub_key), 226);
    wait_idle();

    // Boundary keys on requester 2.
    bkeys = '{8'd2, 8'd3, 8'd226};
    for (int i = 0; i < 3; i++) begin
      key_arr[2] = bkeys[i];
      pend = 4'b0100;
      grant_one(1'b0, w, a);
      wait_idle();
    end

    // Invalid keys on requester 3 leave the pointer at 0 afterwards.
`ifdef PKG_ERR_COUNT_EN
    err_count_clr = 1'b1;
    step();
    err_count_clr = 1'b0;
`endif
    ikeys = '{8'd0, 8'd227, 8'd255};
    for (int i = 0; i < 3; i++) begin
      key_arr[3] = ikeys[i];
      pend = 4'b1000;
      grant_one(1'b0, w, a);
      wait_idle();
    end
`ifdef PKG_ERR_COUNT_EN
    check("err_count_three", int'(err_count), 3);
`endif

    // All four held: strict rotation with 3-cycle grant spacing.
    key_arr[0] = 8'd10; key_arr[1] = 8'd20; key_arr[2] = 8'd30; key_arr[3] = 8'd40;
    pend = 4'b1111;
    last = 0;
    for (int k = 0; k < 5; k++) begin
      grant_one(1'b1, w, a);
      check("rr_order", int'(bus.ack), 1 << (k % NUM_REQ));
      if (k > 0) check("grant_spacing", a - last, 3);
      last = a;
    end
    pend = '0;
    req_drv = '0;
    wait_idle();

    // Backpressure: response held while new requests queue up.
    ready_fixed = 1'b0;
    key_arr[1] = 8'd100;
    pend = 4'b0010;
    grant_one(1'b0, w, a);
    key_arr[0] = 8'd77;
    key_arr[2] = 8'd150;
    pend = 4'b0101;
    req_drv = pend;
    step();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", int'(bus.rsp_valid), 1);
      check("bp_no_ack", int'(bus.ack), 0);
      step();
    end
    ready_fixed = 1'b1;
    grant_one(1'b0, w, a);
    check("bp_next_grant", int'(bus.ack), 4);
    grant_one(1'b0, w, a);
    wait_idle();

    // Randomised traffic with random consumer stalls.
    rdy_rand = 1'b1;
    for (int t = 0; t < 150; t++) begin
      if (pend == '0) begin
        pend = 4'($urandom_range(1, 15));
        for (int i = 0; i < NUM_REQ; i++)
          if (pend[ID_W'(i)]) key_arr[ID_W'(i)] = rand_key();
      end
      grant_one(1'b0, w, a);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pend[ID_W'(i)] && $urandom_range(0, 3) == 0) begin
          pend[ID_W'(i)]    = 1'b1;
          key_arr[ID_W'(i)] = rand_key();
        end else if (pend[ID_W'(i)] && $urandom_range(0, 9) == 0) begin
          pend[ID_W'(i)] = 1'b0;
        end
      end
      req_drv = pend;
    end
    pend = '0;
    req_drv = '0;
    rdy_rand = 1'b0;
    wait_idle();

    // Reset during CALC aborts the transaction and clears the pointer.
    key_arr[2] = 8'd50;
    pend = 4'b0100;
    grant_one(1'b0, w, a);
    rst_n = 1'b1;
    exp_q.delete();
    model_ptr = 0;
    step();
    rst_n = 1'b0;
    check("midrst_rsp_valid", int'(bus.rsp_valid), 0);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_pub_key", int'(bus.rsp_pub_key), 0);
    key_arr[1] = 8'd5;
    key_arr[2] = 8'd6;
    pend = 4'b0110;
    grant_one(1'b0, w, a);
    check("midrst_first_grant", int'(bus.ack), 2);
    grant_one(1'b0, w, a);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
